// File: rtl/lfsr_gen_if.sv
// Word stream carried from lfsr_gen to its consumer: valid/ready handshake
// with an NOUT-bit payload.
interface lfsr_gen_if #(
  parameter int NOUT = 6
);
  logic            out_vld;
  logic            out_rdy;
  logic [NOUT-1:0] out_dat;

  modport master (
    output out_vld,
    output out_dat,
    input  out_rdy
  );

  modport slave (
    input  out_vld,
    input  out_dat,
    output out_rdy
  );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR word generator. Each advance runs NOUT single
// steps in one cycle and presents the feedback bits as a word on a
// valid/ready stream. Supports run-time reseeding with zero-seed substitution,
// a wrap pulse when the state returns to the active seed, and a saturating
// words-since-seed counter.
module lfsr_gen #(
  parameter int              WIDTH = 16,
  parameter int              NOUT  = 6,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] INIT = 16'hBEEF,
  parameter int              CW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed,
  lfsr_gen_if.master       strm,
  output logic [WIDTH-1:0] state,
  output logic             wrap,
  output logic             zseed,
  output logic [CW-1:0]    wcnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fsm_t;

  fsm_t             fsm_q;
  fsm_t             fsm_d;
  logic             adv;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] seed_reg_q;
  logic [WIDTH-1:0] adv_state;
  logic [WIDTH-1:0] ld_val;
  logic [NOUT-1:0]  adv_bits;
  logic [NOUT-1:0]  dat_q;
  logic [CW-1:0]    wcnt_q;
  logic             wrap_q;
  logic             zseed_q;

  // NOUT single Fibonacci steps; the first feedback bit lands in the word MSB,
  // so the low NOUT state bits equal the word afterwards.
  function automatic logic [WIDTH+NOUT-1:0] advance(input logic [WIDTH-1:0] s_in);
    logic [WIDTH-1:0] s;
    logic [NOUT-1:0]  bits;
    logic             fb;
    s    = s_in;
    bits = '0;
    for (int k = 0; k < NOUT; k++) begin
      fb                = ^(s & TAPS);
      bits[NOUT-1-k]    = fb;
      s                 = {s[WIDTH-2:0], fb};
    end
    return {s, bits};
  endfunction

  // Counter increment that sticks at all-ones instead of rolling over.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  assign {adv_state, adv_bits} = advance(lfsr_q);

  // A zero seed would lock the register at zero forever; substitute INIT.
  assign ld_val = (seed == '0) ? INIT : seed;

  // Next-state logic: seed load wins over everything, otherwise generate into
  // an empty slot or replace a word the consumer is taking this cycle.
  always_comb begin
    fsm_d = fsm_q;
    adv   = 1'b0;
    if (seed_ld) begin
      fsm_d = EMPTY;
    end else begin
      case (fsm_q)
        EMPTY: begin
          if (en) begin
            adv   = 1'b1;
            fsm_d = FULL;
          end
        end
        FULL: begin
          if (strm.out_rdy) begin
            if (en) adv = 1'b1;
            else    fsm_d = EMPTY;
          end
        end
        default: fsm_d = EMPTY;
      endcase
    end
  end

  // FSM state register; FULL is exactly "out_vld is high".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm_q <= EMPTY;
    else      fsm_q <= fsm_d;
  end

  // LFSR, active seed, output word, counter and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q     <= INIT;
      seed_reg_q <= INIT;
      dat_q      <= '0;
      wcnt_q     <= '0;
      wrap_q     <= 1'b0;
      zseed_q    <= 1'b0;
    end else if (seed_ld) begin
      lfsr_q     <= ld_val;
      seed_reg_q <= ld_val;
      zseed_q    <= (seed == '0);
      wcnt_q     <= '0;
      wrap_q     <= 1'b0;
    end else begin
      zseed_q <= 1'b0;
      wrap_q  <= 1'b0;
      if (adv) begin
        lfsr_q <= adv_state;
        dat_q  <= adv_bits;
        wcnt_q <= sat_inc(wcnt_q);
        wrap_q <= (adv_state == seed_reg_q);
      end
    end
  end

  assign strm.out_vld = (fsm_q == FULL);
  assign strm.out_dat = dat_q;
  assign state        = lfsr_q;
  assign wrap         = wrap_q;
  assign zseed        = zseed_q;
  assign wcnt         = wcnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Testbench for lfsr_gen: directed checks on three parameter sets plus a
// randomised run of the default configuration against a word-level model.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default configuration
  logic        en0, ld0;
  logic [15:0] seed0, state0;
  logic        wrap0, zseed0;
  logic [31:0] wcnt0;
  lfsr_gen_if #(.NOUT(6)) bus0();
  lfsr_gen #(.WIDTH(16), .NOUT(6), .TAPS(16'hB400), .INIT(16'hBEEF), .CW(32)) u0 (
    .clk(clk), .rst(rst), .en(en0), .seed_ld(ld0), .seed(seed0), .strm(bus0),
    .state(state0), .wrap(wrap0), .zseed(zseed0), .wcnt(wcnt0));

  // One bit per step
  logic        en1, ld1;
  logic [15:0] seed1, state1;
  logic        wrap1, zseed1;
  logic [31:0] wcnt1;
  lfsr_gen_if #(.NOUT(1)) bus1();
  lfsr_gen #(.WIDTH(16), .NOUT(1), .TAPS(16'hB400), .INIT(16'hBEEF), .CW(32)) u1 (
    .clk(clk), .rst(rst), .en(en1), .seed_ld(ld1), .seed(seed1), .strm(bus1),
    .state(state1), .wrap(wrap1), .zseed(zseed1), .wcnt(wcnt1));

  // 4-bit maximal-length register, period 15
  logic        en2, ld2;
  logic [3:0]  seed2, state2;
  logic        wrap2, zseed2;
  logic [31:0] wcnt2;
  lfsr_gen_if #(.NOUT(1)) bus2();
  lfsr_gen #(.WIDTH(4), .NOUT(1), .TAPS(4'hC), .INIT(4'h1), .CW(32)) u2 (
    .clk(clk), .rst(rst), .en(en2), .seed_ld(ld2), .seed(seed2), .strm(bus2),
    .state(state2), .wrap(wrap2), .zseed(zseed2), .wcnt(wcnt2));

  int n_checks = 0;
  int n_errors = 0;
  int n2       = 0;

  // Reference model of the default configuration
  longint unsigned m_state, m_seed, m_wcnt;
  logic [5:0]      m_dat;
  bit              m_vld, m_wrap, m_zseed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit par(input longint unsigned v);
    return bit'($countones(v) & 1);
  endfunction

  task automatic m_reset();
    m_state = 64'hBEEF;
    m_seed  = 64'hBEEF;
    m_wcnt  = 0;
    m_dat   = '0;
    m_vld   = 1'b0;
    m_wrap  = 1'b0;
    m_zseed = 1'b0;
  endtask

  // What one clock edge does to the stream, from the input values at the edge.
  task automatic model_edge(input bit e, input bit r, input bit l, input longint unsigned sd);
    longint unsigned w;
    bit b;
    m_wrap  = 1'b0;
    m_zseed = 1'b0;
    if (l) begin
      m_state = (sd == 0) ? 64'hBEEF : sd;
      m_seed  = m_state;
      m_zseed = (sd == 0);
      m_vld   = 1'b0;
      m_wcnt  = 0;
    end else if (e && (!m_vld || r)) begin
      w = 0;
      for (int k = 0; k < 6; k++) begin
        b       = par(m_state & 64'hB400);
        w       = (w << 1) | longint'(b);
        m_state = ((m_state << 1) | longint'(b)) & 64'hFFFF;
      end
      m_dat  = w[5:0];
      m_vld  = 1'b1;
      if (m_wcnt != 64'hFFFF_FFFF) m_wcnt++;
      m_wrap = (m_state == m_seed);
    end else if (m_vld && r) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic cmp_all();
    check("vld", bus0.out_vld, m_vld);
    if (m_vld) check("dat", bus0.out_dat, m_dat);
    check("state", state0, m_state);
    check("wcnt", wcnt0, m_wcnt);
    check("wrap", wrap0, m_wrap);
    check("zseed", zseed0, m_zseed);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vld"}, bus0.out_vld, 0);
    check({tag, "_dat"}, bus0.out_dat, 0);
    check({tag, "_state"}, state0, 16'hBEEF);
    check({tag, "_wcnt"}, wcnt0, 0);
    check({tag, "_wrap"}, wrap0, 0);
    check({tag, "_zseed"}, zseed0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(en0, bus0.out_rdy, ld0, longint'(seed0));
    #1;
    cmp_all();
    if (en2) begin
      n2++;
      check("wrap4", wrap2, (n2 % 15) == 0);
      if ((n2 % 15) == 0) check("wcnt4_at_wrap", wcnt2, n2);
      if (n2 == 45) en2 = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    en0 = 1'b0; ld0 = 1'b0; seed0 = '0; bus0.out_rdy = 1'b0;
    en1 = 1'b0; ld1 = 1'b0; seed1 = '0; bus1.out_rdy = 1'b1;
    en2 = 1'b0; ld2 = 1'b0; seed2 = '0; bus2.out_rdy = 1'b1;
    m_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");

    rst = 1'b1;
    en0 = 1'b1; bus0.out_rdy = 1'b1;
    en1 = 1'b1;
    en2 = 1'b1;
    tick();
    check("first_dat", bus0.out_dat, 6'h1B);
    check("first_state", state0, 16'hBBDB);
    check("first_wcnt", wcnt0, 1);
    check("n1_dat", bus1.out_dat, 0);
    check("n1_state", state1, 16'h7DDE);
    en1 = 1'b0;

    // Back-pressure holds word, state and count
    bus0.out_rdy = 1'b0;
    repeat (5) begin
      tick();
      check("bp_vld", bus0.out_vld, 1);
      check("bp_dat", bus0.out_dat, 6'h1B);
      check("bp_state", state0, 16'hBBDB);
      check("bp_wcnt", wcnt0, 1);
    end
    bus0.out_rdy = 1'b1;
    tick();
    check("bp_release_wcnt", wcnt0, 2);

    // Zero seed while a word is being accepted
    ld0 = 1'b1; seed0 = 16'h0000;
    tick();
    check("zs_zseed", zseed0, 1);
    check("zs_state", state0, 16'hBEEF);
    check("zs_vld", bus0.out_vld, 0);
    check("zs_wcnt", wcnt0, 0);
    ld0 = 1'b0;
    tick();
    check("zs_after_zseed", zseed0, 0);
    check("zs_after_dat", bus0.out_dat, 6'h1B);
    check("zs_after_wcnt", wcnt0, 1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      en0          = ($urandom_range(0, 9) < 8);
      bus0.out_rdy = ($urandom_range(0, 9) < 7);
      ld0          = ($urandom_range(0, 39) == 0);
      seed0        = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      tick();
    end
    check("wrap4_count", n2, 45);

    // Asynchronous reset between edges
    en0 = 1'b1; bus0.out_rdy = 1'b1; ld0 = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b0;
    #1;
    check_reset_vals("async");
    m_reset();
    #2;
    rst = 1'b1;
    tick();
    check("restart_dat", bus0.out_dat, 6'h1B);
    check("restart_state", state0, 16'hBBDB);
    check("restart_wcnt", wcnt0, 1);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
